// File: rtl/kernel_fifo_sink.sv
// Responder end of an HLS ap_fifo output stream: buffers kernel writes, drains them at
// a programmable rate, folds each drained word to a 4-bit signature and tracks per-run totals.
module kernel_fifo_sink #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int DRAIN_INV      = 1,
  parameter int EXPECTED_WORDS = 4096
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  input  logic                  ap_done,
  input  logic [DATA_WIDTH-1:0] fifo_din,
  input  logic                  fifo_write,
  output logic                  fifo_full_n,
  output logic [3:0]            sig_out,
  output logic                  sig_valid,
  output logic [31:0]           word_count,
  output logic [3:0]            run_sig,
  output logic                  run_done,
  output logic                  count_err,
  output logic                  overflow_err,
  output logic [1:0]            state_dbg
);

  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int DCW    = (DRAIN_INV > 1) ? $clog2(DRAIN_INV) : 1;
  localparam int NBYTES = DATA_WIDTH / 8;

  // Handshake: a word is accepted on a rising ap_clk edge where fifo_write and
  // fifo_full_n are both high; fifo_write while fifo_full_n is low drops the word.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          occ_q, occ_d;
  logic [DCW-1:0]         drain_cnt;
  logic                   push, drop, pop, start_clear, run_end;
  logic [DATA_WIDTH-1:0]  rd_word;
  logic [7:0]             fold_byte;
  logic                   s1_valid;
  logic [7:0]             s1_byte;
  logic [3:0]             s2_nibble;

  assign push        = fifo_write & fifo_full_n;
  assign drop        = fifo_write & ~fifo_full_n;
  assign pop         = (drain_cnt == DCW'(DRAIN_INV - 1)) && (occ_q != '0);
  assign start_clear = (state_q == S_IDLE) && ap_start;
  assign run_end     = (state_q == S_FLUSH) && (state_d == S_DONE);
  assign rd_word     = mem[rd_ptr];
  assign s2_nibble   = s1_byte[7:4] ^ s1_byte[3:0];
  assign run_done    = (state_q == S_DONE);
  assign state_dbg   = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ap_start) state_d = S_RUN;
      S_RUN:   if (ap_done) state_d = S_FLUSH;
      // A push in the same cycle would leave a word behind, so wait for it too.
      S_FLUSH: if ((occ_q == '0) && !push && !s1_valid && !sig_valid) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop)
      occ_d = occ_q + CW'(1);
    else if (pop && !push)
      occ_d = occ_q - CW'(1);
  end

  always_comb begin
    fold_byte = '0;
    for (int i = 0; i < NBYTES; i++)
      fold_byte = fold_byte ^ rd_word[i*8 +: 8];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      occ_q       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      drain_cnt   <= '0;
      fifo_full_n <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (drain_cnt == DCW'(DRAIN_INV - 1))
        drain_cnt <= '0;
      else
        drain_cnt <= drain_cnt + DCW'(1);
      // Registered so it describes the occupancy seen at the start of each cycle.
      fifo_full_n <= ((state_d == S_RUN) || (state_d == S_FLUSH)) &&
                     (occ_d < CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= fifo_din;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid  <= 1'b0;
      s1_byte   <= '0;
      sig_valid <= 1'b0;
      sig_out   <= '0;
    end else begin
      s1_valid  <= pop;
      if (pop) s1_byte <= fold_byte;
      sig_valid <= s1_valid;
      if (s1_valid) sig_out <= s2_nibble;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      word_count   <= '0;
      run_sig      <= '0;
      count_err    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (start_clear)
        word_count <= '0;
      else if (push && (word_count != 32'hFFFF_FFFF))
        word_count <= word_count + 32'd1;

      // Folded in on the edge that raises sig_valid, so both appear together.
      if (start_clear)
        run_sig <= '0;
      else if (s1_valid)
        run_sig <= run_sig ^ s2_nibble;

      if (start_clear)
        count_err <= 1'b0;
      else if (run_end)
        count_err <= (word_count != 32'(EXPECTED_WORDS));

      // A dropped write wins over the clear: it belongs to the run being started.
      if (drop)
        overflow_err <= 1'b1;
      else if (start_clear)
        overflow_err <= 1'b0;
    end
  end

endmodule

// File: doc/kernel_fifo_sink.md
Name: kernel_fifo_sink

Overview:
Responder end of the HLS ap_fifo output interface (din/full_n/write) driven by an accelerator kernel's streamed outputs. It buffers accepted words in a small FIFO and drains them at a programmable rate, so kernel back-pressure can be exercised. Each drained word is XOR-folded to a 4-bit signature for low-pin observation. Per run it counts words, checks the count against an expected total and reports a run-level signature. One instance sits beside the kernel per output partition.

Parameters:
DATA_WIDTH, 32, width of fifo_din; must be a multiple of 8.
FIFO_DEPTH, 16, buffer entries; power of two, at least 2.
DRAIN_INV, 1, cycles per drain opportunity; 1 means one pop per cycle; must be at least 1.
EXPECTED_WORDS, 4096, words expected per run.

Ports:
ap_clk  in  1  clock.
ap_rst_n  in  1  asynchronous reset, active-low.
ap_start  in  1  run start (pulse or level, edge not required).
ap_done  in  1  kernel done pulse.
fifo_din  in  DATA_WIDTH  write data from kernel.
fifo_write  in  1  write strobe from kernel.
fifo_full_n  out  1  high = space available.
sig_out  out  4  folded signature of the drained word.
sig_valid  out  1  sig_out qualifier, one-cycle pulse per word.
word_count  out  32  words accepted in the current run.
run_sig  out  4  XOR of all sig_out values of the current run.
run_done  out  1  one-cycle pulse at end of run.
count_err  out  1  sticky; word_count != EXPECTED_WORDS at run end.
overflow_err  out  1  sticky; write seen while fifo_full_n low.

Behaviour:
- Reset (ap_rst_n low, async): state IDLE, FIFO empty, drain counter 0. All outputs 0, including fifo_full_n.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: ap_start high -> RUN. Same edge clears word_count, run_sig, count_err, overflow_err. ap_done in IDLE is ignored; simultaneous ap_start+ap_done -> RUN.
  - RUN: ap_done high -> FLUSH. ap_start is ignored.
  - FLUSH: FIFO empty and fold pipeline empty -> DONE.
  - DONE: run_done=1 and count_err updated for one cycle -> IDLE.
- fifo_full_n = (state is RUN or FLUSH) and (occupancy < FIFO_DEPTH). Registered: it reflects occupancy at the start of the cycle.
- Accept: fifo_write && fifo_full_n pushes fifo_din and increments word_count. word_count saturates at 0xFFFFFFFF.
- fifo_write && !fifo_full_n: data dropped, overflow_err set (sticky until the next ap_start).
- Drain counter runs 0..DRAIN_INV-1 and wraps.
  - A pop occurs when the counter equals DRAIN_INV-1 and occupancy > 0 at the start of the cycle.
  - There is no fall-through: a word written into an empty FIFO pops at the earliest on the following cycle.
- Simultaneous push and pop: occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
- Fold pipeline:
  - Stage 1 (cycle after pop): XOR of all bytes of the word -> 8 bits.
  - Stage 2: high nibble XOR low nibble -> sig_out, with sig_valid=1.
  - Latency is 2 cycles from pop to sig_valid; throughput is 1 word/cycle.
- run_sig is XORed with each sig_out in the same cycle as sig_valid, and holds after run end until the next ap_start.
- count_err is evaluated on the DONE cycle, after saturation.

Test Plan:
1. DRAIN_INV=1; ap_start, then 4096 back-to-back writes of 0x01020304, then ap_done -> fifo_full_n never low in RUN; each sig_out=4 two cycles after its pop; run_sig=0; word_count=4096; run_done pulses once; count_err=0; overflow_err=0.
2. Single word 0x12345678, EXPECTED_WORDS=1 -> sig_out=8; run_sig=8; count_err=0.
3. DRAIN_INV=4; kernel honours full_n while writing 64 words -> fifo_full_n drops once 16 words are held, then toggles; all 64 sig_valid pulses arrive; word_count=64; overflow_err=0.
4. fifo_write held with fifo_full_n low (FIFO full, and separately while in IDLE) -> overflow_err=1; word_count unchanged; no sig_valid for the dropped data.
5. 100 writes, ap_done while the FIFO is still non-empty -> all remaining words drain in FLUSH, then run_done pulses with count_err=1.
6. ap_rst_n pulled low mid-FLUSH -> all outputs 0 immediately (async); after release state is IDLE; a new ap_start run behaves as in scenario 1.
